shift_add_mac: RTL
==================

Name: shift_add_mac

Overview:
- Sequential unsigned multiply-accumulate processing element for the matrix multiplier datapath.
- Consumes operand pairs over a valid/ready handshake and forms each product by shift-and-add over WIDTH cycles.
- Accumulates products into a dot-product register and emits the sum when the operand tagged Last has been absorbed.
- The adders inside are ripple-carry chains built from the team's half/full adder cells. The block sits between the operand fetch logic and the result store.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- ACC_W, 24, accumulator/result width; must be >= 2*WIDTH (elaboration-time assertion).

Ports:
- Clk  input  1  clock, rising-edge.
- Rst  input  1  reset, asynchronous, active-high.
- InValid  input  1  operand pair valid.
- InReady  output  1  block can accept an operand pair.
- A  input  WIDTH  multiplicand, unsigned.
- B  input  WIDTH  multiplier, unsigned.
- Last  input  1  marks the final pair of a dot product.
- OutValid  output  1  Result holds a completed dot product.
- OutReady  input  1  consumer accepts Result.
- Result  output  ACC_W  accumulated dot product.

Behaviour:
- Reset values: state IDLE; acc=0; product=0; count=0; OutValid=0; Result=0. InReady is forced to 0 while Rst is high.
- State machine: IDLE, MUL, ACC, DONE.
- InReady = (state==IDLE). OutValid = (state==DONE). Result is driven directly from the acc register.
- IDLE:
  - On InValid&InReady, capture: mcand = zero-extended A (2*WIDTH bits); mplier = B; product = 0; count = 0; last_q = Last.
  - Then go to MUL.
  - With InValid low, stay in IDLE.
- MUL, one iteration per cycle:
  - If mplier[0], product <= product + mcand, as a 2*WIDTH-bit add with no overflow possible.
  - mcand <<= 1; mplier >>= 1; count++.
  - After exactly WIDTH iterations, go to ACC.
  - Latency is fixed. There is no early exit for zero operands.
- ACC, one cycle:
  - acc <= acc + zero-extended product, modulo 2^ACC_W (wraps silently).
  - If last_q, go to DONE; otherwise go to IDLE.
- DONE:
  - Hold OutValid=1 and Result stable until OutReady=1.
  - On that handshake cycle: acc <= 0 and go to IDLE.
  - If OutReady was already high on entry, OutValid is high for exactly one cycle.
- Timing:
  - Acceptance edge to InReady re-asserting (non-Last pair): WIDTH+1 cycles.
  - Acceptance edge to OutValid asserting (Last pair): WIDTH+1 cycles.
- InValid, A, B and Last are ignored outside IDLE. The upstream stage must hold them until the handshake completes.
- Reset mid-operation (any state) abandons the partial product and the accumulator. All registers return to reset values, and no output handshake occurs.
- A back-to-back stream gives maximum throughput of one pair per WIDTH+1 cycles. No input skid buffer.

Optional Feature:
- Macro: SHIFT_ADD_MAC_OVF_EN.
- Defined:
  - Adds output port Overflow (1 bit). Its reset value is 0.
  - Overflow is sticky: it is set whenever the accumulator adder carries out of ACC_W bits.
  - It is meaningful while OutValid=1 and is cleared together with acc on the output handshake.
- Undefined: no Overflow port and no carry-out tracking; accumulation wraps silently.

Decomposition:
- Package mac_pkg holds:
  - the typedef enum logic [1:0] state type {IDLE, MUL, ACC, DONE};
  - default constants MAC_WIDTH=8 and MAC_ACC_W=24.
- One natural sub-module: rca_adder #(N), an N-bit ripple-carry adder with Cin and Cout, chained from half/full adder cells.
- rca_adder is instantiated twice: N=2*WIDTH for the product adder and N=ACC_W for the accumulator adder, whose Cout feeds Overflow.

Test Plan:
- Single pair: reset, then A=3, B=5, Last=1 with OutReady=1 → OutValid rises 9 cycles after the accept edge, Result=15, OutValid high for exactly 1 cycle.
- Dot product: pairs (1,2), (3,4), (5,6) with Last on the third → no OutValid after the first two pairs, InReady returns 9 cycles after each accept, final Result=44.
- Extremes: A=255, B=255, Last=1 → Result=65025. A=0, B=200 → Result=0 with the same 9-cycle latency.
- Backpressure: after the 44 dot product, hold OutReady=0 for 5 cycles → Result stays 44, OutValid=1, InReady=0. Then raise OutReady and send pair (2,2) with Last → Result=4, confirming acc was cleared.
- Reset mid-operation: accept A=7, B=9, assert Rst on the 4th MUL cycle → all outputs at reset values immediately. After release, pair (2,3) with Last → Result=6.
- Overflow (SHIFT_ADD_MAC_OVF_EN, ACC_W=16): pairs (255,255), (255,255) with Last → Result=64514, Overflow=1. The next dot product (1,1) → Result=1, Overflow=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default sizing for the shift-and-add multiply-accumulate element.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        DONE
    } state_t;

    localparam int unsigned MAC_WIDTH = 8;
    localparam int unsigned MAC_ACC_W = 24;

endpackage

// File: rtl/rca_adder.sv
// N-bit ripple-carry adder; each bit is a full adder built from two half-adder stages.
module rca_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic [N:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic p, g, pc;
        // First half adder: propagate/generate; second half adder folds in the carry.
        assign p            = A[i] ^ B[i];
        assign g            = A[i] & B[i];
        assign Sum[i]       = p ^ carry[i];
        assign pc           = p & carry[i];
        assign carry[i + 1] = g | pc;
    end

    assign Cout = carry[N];

endmodule

// File: rtl/shift_add_mac.sv
// Sequential unsigned shift-and-add multiply-accumulate element with valid/ready handshakes.
// Optional sticky accumulator carry-out flag when SHIFT_ADD_MAC_OVF_EN is defined.
module shift_add_mac
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = MAC_WIDTH,
    parameter int unsigned ACC_W = MAC_ACC_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Last,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [ACC_W-1:0] Result
`ifdef SHIFT_ADD_MAC_OVF_EN
    ,
    output logic             Overflow
`endif
);

    localparam int unsigned P_W   = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 2) begin : g_width_check
        $error("WIDTH must be at least 2");
    end
    if (ACC_W < 2 * WIDTH) begin : g_acc_w_check
        $error("ACC_W must be at least 2*WIDTH");
    end

    state_t             state_q, state_d;
    logic [P_W-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [P_W-1:0]     product_q, product_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               last_q, last_d;
    logic [ACC_W-1:0]   acc_q, acc_d;

    logic [P_W-1:0]     prod_sum;
    logic               prod_cout;
    logic [ACC_W-1:0]   acc_sum;
    logic               acc_cout;

    rca_adder #(
        .N (P_W)
    ) u_prod_adder (
        .A    (product_q),
        .B    (mcand_q),
        .Cin  (1'b0),
        .Sum  (prod_sum),
        .Cout (prod_cout)
    );

    rca_adder #(
        .N (ACC_W)
    ) u_acc_adder (
        .A    (acc_q),
        .B    (ACC_W'(product_q)),
        .Cin  (1'b0),
        .Sum  (acc_sum),
        .Cout (acc_cout)
    );

    // The shifted multiplicand never pushes the product past 2*WIDTH bits.
    logic unused_prod_cout;
    assign unused_prod_cout = prod_cout;

`ifdef SHIFT_ADD_MAC_OVF_EN
    logic ovf_q, ovf_d;
    assign Overflow = ovf_q;
`else
    logic unused_acc_cout;
    assign unused_acc_cout = acc_cout;
`endif

    assign InReady  = (state_q == IDLE) && !Rst;
    assign OutValid = (state_q == DONE);
    assign Result   = acc_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        count_d   = count_q;
        last_d    = last_q;
        acc_d     = acc_q;
`ifdef SHIFT_ADD_MAC_OVF_EN
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (InValid) begin
                    mcand_d   = {{WIDTH{1'b0}}, A};
                    mplier_d  = B;
                    product_d = '0;
                    count_d   = '0;
                    last_d    = Last;
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    product_d = prod_sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = acc_sum;
`ifdef SHIFT_ADD_MAC_OVF_EN
                ovf_d = ovf_q | acc_cout;
`endif
                state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                if (OutReady) begin
                    acc_d   = '0;
`ifdef SHIFT_ADD_MAC_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
            last_q    <= 1'b0;
            acc_q     <= '0;
`ifdef SHIFT_ADD_MAC_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            count_q   <= count_d;
            last_q    <= last_d;
            acc_q     <= acc_d;
`ifdef SHIFT_ADD_MAC_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

endmodule
